// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse encoder.
//   state_e : encoder FSM states
//   code_t  : decoded character {elem_cnt, elem_bits}; elem_bits is LSB-first, 1 = dash
//   *_UNITS : phase lengths in Morse time units
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMark,
    StGap,
    StLetterGap,
    StWordGap
  } state_e;

  localparam int unsigned DOT_UNITS        = 1;
  localparam int unsigned DASH_UNITS       = 3;
  localparam int unsigned GAP_UNITS        = 1;
  localparam int unsigned LETTER_UNITS     = 3;
  localparam int unsigned WORD_EXTRA_UNITS = 4;

  typedef struct packed {
    logic [2:0] elem_cnt;
    logic [4:0] elem_bits;
  } code_t;

endpackage

// File: rtl/morse_encoder_if.sv
// Character handshake between a producer and the Morse encoder.
//   char_valid : producer offers char_data
//   char_data  : ASCII character
//   char_ready : encoder can accept a character this cycle
interface morse_encoder_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/morse_rom.sv
// Combinational ASCII-to-Morse lookup.
//   char_data : ASCII input (letters are case-insensitive)
//   code      : element count and LSB-first element bits (1 = dash)
//   is_symbol : char_data is a letter or digit
//   is_space  : char_data is 0x20
module morse_rom
  import morse_pkg::*;
(
  input  logic [7:0] char_data,
  output code_t      code,
  output logic       is_symbol,
  output logic       is_space
);

  logic [7:0] up;

  always_comb begin
    up        = char_data;
    code      = '0;
    is_symbol = 1'b1;
    is_space  = 1'b0;
    if (char_data >= 8'h61 && char_data <= 8'h7A) begin
      up = char_data - 8'h20;
    end
    case (up)
      8'h41: code = '{3'd2, 5'b00010}; // A .-
      8'h42: code = '{3'd4, 5'b00001}; // B -...
      8'h43: code = '{3'd4, 5'b00101}; // C -.-.
      8'h44: code = '{3'd3, 5'b00001}; // D -..
      8'h45: code = '{3'd1, 5'b00000}; // E .
      8'h46: code = '{3'd4, 5'b00100}; // F ..-.
      8'h47: code = '{3'd3, 5'b00011}; // G --.
      8'h48: code = '{3'd4, 5'b00000}; // H ....
      8'h49: code = '{3'd2, 5'b00000}; // I ..
      8'h4A: code = '{3'd4, 5'b01110}; // J .---
      8'h4B: code = '{3'd3, 5'b00101}; // K -.-
      8'h4C: code = '{3'd4, 5'b00010}; // L .-..
      8'h4D: code = '{3'd2, 5'b00011}; // M --
      8'h4E: code = '{3'd2, 5'b00001}; // N -.
      8'h4F: code = '{3'd3, 5'b00111}; // O ---
      8'h50: code = '{3'd4, 5'b00110}; // P .--.
      8'h51: code = '{3'd4, 5'b01011}; // Q --.-
      8'h52: code = '{3'd3, 5'b00010}; // R .-.
      8'h53: code = '{3'd3, 5'b00000}; // S ...
      8'h54: code = '{3'd1, 5'b00001}; // T -
      8'h55: code = '{3'd3, 5'b00100}; // U ..-
      8'h56: code = '{3'd4, 5'b01000}; // V ...-
      8'h57: code = '{3'd3, 5'b00110}; // W .--
      8'h58: code = '{3'd4, 5'b01001}; // X -..-
      8'h59: code = '{3'd4, 5'b01101}; // Y -.--
      8'h5A: code = '{3'd4, 5'b00011}; // Z --..
      8'h30: code = '{3'd5, 5'b11111}; // 0 -----
      8'h31: code = '{3'd5, 5'b11110}; // 1 .----
      8'h32: code = '{3'd5, 5'b11100}; // 2 ..---
      8'h33: code = '{3'd5, 5'b11000}; // 3 ...--
      8'h34: code = '{3'd5, 5'b10000}; // 4 ....-
      8'h35: code = '{3'd5, 5'b00000}; // 5 .....
      8'h36: code = '{3'd5, 5'b00001}; // 6 -....
      8'h37: code = '{3'd5, 5'b00011}; // 7 --...
      8'h38: code = '{3'd5, 5'b00111}; // 8 ---..
      8'h39: code = '{3'd5, 5'b01111}; // 9 ----.
      default: begin
        is_symbol = 1'b0;
        is_space  = (up == 8'h20);
      end
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Keys ASCII characters out as Morse code on a single LED.
//   UNIT_DIV : clock cycles per Morse time unit (>= 2)
//   clk, rst : clock and synchronous active-high reset
//   bus      : character handshake (slave side)
//   led      : registered keyed output, 1 = mark
//   busy     : a character (or word gap) is in progress
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_DIV = 4194304
) (
  input  logic                  clk,
  input  logic                  rst,
  morse_encoder_if.slave        bus,
  output logic                  led,
  output logic                  busy
);

  localparam int unsigned DivW = (UNIT_DIV > 2) ? $clog2(UNIT_DIV) : 1;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      unit_q, unit_d;
  logic [4:0]      elem_bits_q, elem_bits_d;
  logic [2:0]      elem_cnt_q, elem_cnt_d;
  logic            led_q;

  code_t rom_code;
  logic  rom_symbol;
  logic  rom_space;

  morse_rom u_rom (
    .char_data (bus.char_data),
    .code      (rom_code),
    .is_symbol (rom_symbol),
    .is_space  (rom_space)
  );

  logic       accept;
  logic       unit_tick;
  logic [1:0] last_unit;
  logic       phase_done;

  assign accept    = bus.char_valid && (state_q == StIdle);
  assign unit_tick = (div_q == DivW'(UNIT_DIV - 1));

  // Index of the final unit of the current phase.
  always_comb begin
    last_unit = '0;
    unique case (state_q)
      StMark:      last_unit = elem_bits_q[0] ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
      StGap:       last_unit = 2'(GAP_UNITS - 1);
      StLetterGap: last_unit = 2'(LETTER_UNITS - 1);
      StWordGap:   last_unit = 2'(WORD_EXTRA_UNITS - 1);
      default:     last_unit = '0;
    endcase
  end

  assign phase_done = unit_tick && (unit_q == last_unit);

  always_comb begin
    state_d     = state_q;
    div_d       = unit_tick ? '0 : div_q + 1'b1;
    unit_d      = unit_tick ? unit_q + 2'd1 : unit_q;
    elem_bits_d = elem_bits_q;
    elem_cnt_d  = elem_cnt_q;

    unique case (state_q)
      StIdle: begin
        div_d  = '0;
        unit_d = '0;
        if (accept) begin
          elem_bits_d = rom_code.elem_bits;
          elem_cnt_d  = rom_code.elem_cnt;
          if (rom_symbol) begin
            state_d = StMark;
          end else if (rom_space) begin
            state_d = StWordGap;
          end
          // Unknown characters are consumed and the block stays ready.
        end
      end
      StMark: begin
        if (phase_done) begin
          elem_bits_d = elem_bits_q >> 1;
          elem_cnt_d  = elem_cnt_q - 3'd1;
          state_d     = (elem_cnt_q == 3'd1) ? StLetterGap : StGap;
        end
      end
      StGap: begin
        if (phase_done) state_d = StMark;
      end
      StLetterGap, StWordGap: begin
        if (phase_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Every phase boundary restarts unit timing so elements never drift.
    if (state_q != StIdle && phase_done) begin
      div_d  = '0;
      unit_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      unit_q      <= '0;
      elem_bits_q <= '0;
      elem_cnt_q  <= '0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      unit_q      <= unit_d;
      elem_bits_q <= elem_bits_d;
      elem_cnt_q  <= elem_cnt_d;
      led_q       <= (state_d == StMark);
    end
  end

  assign led            = led_q;
  assign busy           = (state_q != StIdle);
  assign bus.char_ready = (state_q == StIdle);

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_DIV = 4 (one unit = 4 clocks).
module tb_morse_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led;
  logic busy;

  morse_encoder_if bus ();

  morse_encoder #(.UNIT_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .led  (led),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       led_tr  [0:255];
  logic       busy_tr [0:255];
  logic       rdy_tr  [0:255];
  logic [7:0] stim_q  [$];
  int         acc_idx [$];
  bit         exp_led [$];
  bit         exp_busy[$];

  // Sample index i is the negedge after i clock edges; a character offered at sample i
  // is accepted on the following posedge if char_ready was high.
  task automatic run_stream(input int n);
    acc_idx.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      led_tr[i]  = led;
      busy_tr[i] = busy;
      rdy_tr[i]  = bus.char_ready;
      if (stim_q.size() > 0) begin
        bus.char_valid = 1'b1;
        bus.char_data  = stim_q[0];
      end else begin
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
      end
      @(posedge clk);
      if (bus.char_valid && rdy_tr[i]) begin
        acc_idx.push_back(i);
        void'(stim_q.pop_front());
      end
    end
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic add_led(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_led.push_back(v);
  endtask

  task automatic add_busy(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_busy.push_back(v);
  endtask

  task automatic clear_exp();
    exp_led.delete();
    exp_busy.delete();
  endtask

  task automatic test_reset();
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (led !== 1'b0 || busy !== 1'b0 || bus.char_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset: led=%b busy=%b ready=%b, want 0 0 1", led, busy, bus.char_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_letter_e(input logic [7:0] ch, input string tag);
    stim_q = '{ch};
    run_stream(24);
    clear_exp();
    add_led(0, 1);  add_led(1, 4);   add_led(0, 19);
    add_busy(0, 1); add_busy(1, 16); add_busy(0, 7);
    for (int i = 0; i < 24; i++) begin
      tests_run++;
      if (led_tr[i] !== exp_led[i] || busy_tr[i] !== exp_busy[i] || rdy_tr[i] !== !exp_busy[i]) begin
        tests_failed++;
        $display("FAIL %s[%0d]: led/busy/ready=%b%b%b, want %b%b%b", tag, i, led_tr[i], busy_tr[i],
                 rdy_tr[i], exp_led[i], exp_busy[i], !exp_busy[i]);
      end
    end
    tests_run++;
    if (acc_idx.size() != 1) begin
      tests_failed++;
      $display("FAIL %s accepts: got %0d, want 1", tag, acc_idx.size());
    end
  endtask

  task automatic test_letter_a();
    int bcnt;
    stim_q = '{8'h41};
    run_stream(40);
    clear_exp();
    add_led(0, 1); add_led(1, 4); add_led(0, 4); add_led(1, 12); add_led(0, 19);
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_tr[i] === 1'b1) bcnt++;
      tests_run++;
      if (led_tr[i] !== exp_led[i]) begin
        tests_failed++;
        $display("FAIL A led[%0d]: got %b, want %b", i, led_tr[i], exp_led[i]);
      end
    end
    tests_run++;
    if (bcnt != 32 || busy_tr[32] !== 1'b1 || busy_tr[33] !== 1'b0) begin
      tests_failed++;
      $display("FAIL A busy: %0d cycles (end %b%b), want 32 (end 10)", bcnt, busy_tr[32], busy_tr[33]);
    end
  endtask

  task automatic test_digit_zero();
    stim_q = '{8'h30};
    run_stream(96);
    clear_exp();
    add_led(0, 1);
    for (int e = 0; e < 5; e++) begin
      add_led(1, 12);
      if (e < 4) add_led(0, 4);
    end
    add_led(0, 96 - exp_led.size());
    add_busy(0, 1); add_busy(1, 88); add_busy(0, 7);
    for (int i = 0; i < 96; i++) begin
      tests_run++;
      if (led_tr[i] !== exp_led[i] || busy_tr[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL zero[%0d]: led/busy=%b%b, want %b%b", i, led_tr[i], busy_tr[i],
                 exp_led[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_space_after_t();
    int low_run;
    // char_data switches to space while T is still busy; it must only take effect when ready.
    stim_q = '{8'h54, 8'h20};
    run_stream(48);
    clear_exp();
    add_led(0, 1); add_led(1, 12); add_led(0, 35);
    add_busy(0, 1); add_busy(1, 24); add_busy(0, 1); add_busy(1, 16); add_busy(0, 6);
    for (int i = 0; i < 48; i++) begin
      tests_run++;
      if (led_tr[i] !== exp_led[i] || busy_tr[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL T_space[%0d]: led/busy=%b%b, want %b%b", i, led_tr[i], busy_tr[i],
                 exp_led[i], exp_busy[i]);
      end
    end
    low_run = 0;
    for (int i = 13; i < 41 && led_tr[i] === 1'b0; i++) low_run++;
    tests_run++;
    if (low_run != 28 || acc_idx.size() != 2 || acc_idx[1] != 25) begin
      tests_failed++;
      $display("FAIL T_space gap: low=%0d accepts=%0d, want 28 2 (second at 25)",
               low_run, acc_idx.size());
    end
  endtask

  task automatic test_unknown();
    stim_q = '{8'h23};
    run_stream(10);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (led_tr[i] !== 1'b0 || busy_tr[i] !== 1'b0 || rdy_tr[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL hash[%0d]: led/busy/ready=%b%b%b, want 001", i, led_tr[i], busy_tr[i], rdy_tr[i]);
      end
    end
    // Unknown followed immediately by E: no bubble, E accepted at the very next edge.
    stim_q = '{8'h23, 8'h45};
    run_stream(24);
    clear_exp();
    add_led(0, 2); add_led(1, 4); add_led(0, 18);
    add_busy(0, 2); add_busy(1, 16); add_busy(0, 6);
    for (int i = 0; i < 24; i++) begin
      tests_run++;
      if (led_tr[i] !== exp_led[i] || busy_tr[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL hash_E[%0d]: led/busy=%b%b, want %b%b", i, led_tr[i], busy_tr[i],
                 exp_led[i], exp_busy[i]);
      end
    end
    tests_run++;
    if (acc_idx.size() != 2 || acc_idx[1] != 1) begin
      tests_failed++;
      $display("FAIL hash_E accepts: got %0d, want 2 (second at 1)", acc_idx.size());
    end
  endtask

  task automatic test_back_to_back_sos();
    stim_q = '{8'h53, 8'h4F, 8'h53};
    run_stream(130);
    clear_exp();
    add_led(0, 1);
    add_led(1, 4); add_led(0, 4); add_led(1, 4); add_led(0, 4); add_led(1, 4);
    add_led(0, 13);
    add_led(1, 12); add_led(0, 4); add_led(1, 12); add_led(0, 4); add_led(1, 12);
    add_led(0, 13);
    add_led(1, 4); add_led(0, 4); add_led(1, 4); add_led(0, 4); add_led(1, 4);
    add_led(0, 130 - exp_led.size());
    add_busy(0, 1); add_busy(1, 32); add_busy(0, 1); add_busy(1, 56); add_busy(0, 1);
    add_busy(1, 32); add_busy(0, 7);
    for (int i = 0; i < 130; i++) begin
      tests_run++;
      if (led_tr[i] !== exp_led[i] || busy_tr[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL SOS[%0d]: led/busy=%b%b, want %b%b", i, led_tr[i], busy_tr[i],
                 exp_led[i], exp_busy[i]);
      end
    end
    tests_run++;
    if (acc_idx.size() != 3 || acc_idx[1] != 33 || acc_idx[2] != 90) begin
      tests_failed++;
      $display("FAIL SOS accepts: got %0d, want 3 at 0/33/90", acc_idx.size());
    end
  endtask

  task automatic test_reset_mid_char();
    stim_q = '{8'h4F};
    run_stream(21);
    // Now inside the second dash of O.
    tests_run++;
    if (led !== 1'b1) begin
      tests_failed++;
      $display("FAIL O second dash: led=%b, want 1", led);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (led !== 1'b0 || bus.char_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid reset: led/ready/busy=%b%b%b, want 010", led, bus.char_ready, busy);
    end
    test_letter_e(8'h45, "E_after_rst");
    tests_run++;
    if (acc_idx.size() < 1 || acc_idx[0] != 0) begin
      tests_failed++;
      $display("FAIL post-reset accept: first accept not at first offer");
    end
  endtask

  initial begin
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    test_reset();
    test_letter_e(8'h45, "E");
    test_letter_a();
    test_letter_e(8'h65, "e_lower");
    test_digit_zero();
    test_space_after_t();
    test_unknown();
    test_back_to_back_sos();
    test_reset_mid_char();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
